// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: divides the system clock into pixel strobes, scans
// horizontal/vertical counters and decodes sync, display-enable and
// coordinate outputs. A started frame is always finished before going idle.
module vga_timing_ctrl #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       run,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       disp_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter limits; sync bounds use 11 bits because a sync end may equal 1024.
  localparam logic [3:0]  DIV_LAST = 4'(DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  logic        pix_en_q, pix_en_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        disp_en_q, disp_en_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;

  logic        h_wrap_s;
  logic        frame_end_s;

  // pix_en_q is the strobe of the current cycle, so it drives counter advance.
  assign h_wrap_s    = pix_en_q && (h_cnt_q == H_LAST);
  assign frame_end_s = h_wrap_s && (v_cnt_q == V_LAST);

  // Next state, counters, and the outputs decoded from those next values so
  // the registered outputs always match the registered counters.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;

    case (state_q)
      IDLE: begin
        if (run) state_d = SCAN;
        else     state_d = IDLE;
      end
      SCAN: begin
        if (!run) state_d = DRAIN;
        else      state_d = SCAN;
      end
      DRAIN: begin
        if (run)              state_d = SCAN;
        else if (frame_end_s) state_d = IDLE;
        else                  state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      div_cnt_d = 4'd0;
      h_cnt_d   = 10'd0;
      v_cnt_d   = 10'd0;
    end else begin
      if (div_cnt_q == DIV_LAST) div_cnt_d = 4'd0;
      else                       div_cnt_d = div_cnt_q + 4'd1;
      if (pix_en_q) begin
        if (h_wrap_s) begin
          h_cnt_d = 10'd0;
          if (v_cnt_q == V_LAST) v_cnt_d = 10'd0;
          else                   v_cnt_d = v_cnt_q + 10'd1;
        end else begin
          h_cnt_d = h_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q;
      end
    end

    busy_d        = (state_d != IDLE);
    pix_en_d      = busy_d && (div_cnt_d == DIV_LAST);
    hsync_d       = !(({1'b0, h_cnt_d} >= HS_BEG) && ({1'b0, h_cnt_d} < HS_END));
    vsync_d       = !(({1'b0, v_cnt_d} >= VS_BEG) && ({1'b0, v_cnt_d} < VS_END));
    disp_en_d     = busy_d && ({1'b0, h_cnt_d} < H_ACT_L) && ({1'b0, v_cnt_d} < V_ACT_L);
    x_d           = disp_en_d ? h_cnt_d : 10'd0;
    y_d           = disp_en_d ? v_cnt_d : 10'd0;
    frame_start_d = pix_en_d && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
  end

  // State, counter and output registers; reset forces idle values at once.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_cnt_q     <= 4'd0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      pix_en_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      disp_en_q     <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_en_q      <= pix_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_en_q     <= disp_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small-geometry instance (DIV=2), a DIV=1
// instance and a default-geometry instance, checked with a vector table,
// hand sequences and a random run pattern against a pixel-index model.
module tb_vga_timing_ctrl;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int T   = SHT * SVT;

  // {busy, pix_en, frame_start, disp_en, hsync, vsync, x, y}
  localparam logic [25:0] IDLE_V  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};
  localparam logic [25:0] START_V = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
  localparam logic [25:0] FIRST_V = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst_n, s_run, d_rst_n, d_run;
  logic s_pix, s_hs, s_vs, s_disp, s_fs, s_busy;
  logic o_pix, o_hs, o_vs, o_disp, o_fs, o_busy;
  logic d_pix, d_hs, d_vs, d_disp, d_fs, d_busy;
  logic [9:0] s_x, s_y, o_x, o_y, d_x, d_y;
  logic [25:0] obs_s, obs_1, obs_d;

  assign obs_s = {s_busy, s_pix, s_fs, s_disp, s_hs, s_vs, s_x, s_y};
  assign obs_1 = {o_busy, o_pix, o_fs, o_disp, o_hs, o_vs, o_x, o_y};
  assign obs_d = {d_busy, d_pix, d_fs, d_disp, d_hs, d_vs, d_x, d_y};

  vga_timing_ctrl #(.DIV(2), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_small (
    .clk_in(clk), .rst_n(s_rst_n), .run(s_run), .pix_en(s_pix), .hsync(s_hs),
    .vsync(s_vs), .disp_en(s_disp), .x(s_x), .y(s_y), .frame_start(s_fs), .busy(s_busy));

  vga_timing_ctrl #(.DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_div1 (
    .clk_in(clk), .rst_n(s_rst_n), .run(s_run), .pix_en(o_pix), .hsync(o_hs),
    .vsync(o_vs), .disp_en(o_disp), .x(o_x), .y(o_y), .frame_start(o_fs), .busy(o_busy));

  vga_timing_ctrl u_def (
    .clk_in(clk), .rst_n(d_rst_n), .run(d_run), .pix_en(d_pix), .hsync(d_hs),
    .vsync(d_vs), .disp_en(d_disp), .x(d_x), .y(d_y), .frame_start(d_fs), .busy(d_busy));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit busy;
    bit drain;
    int phase;
    int pix;
  } mdl_t;

  typedef struct {
    logic        run;
    logic [25:0] exp;
  } vec_t;

  // Reference: scanning position as a linear pixel index within the frame.
  function automatic mdl_t mdl_next(mdl_t m, bit r, int d);
    mdl_t n = m;
    bit pe = m.busy && (m.phase == d - 1);
    bit fend = pe && (m.pix == T - 1);
    if (!m.busy) begin
      n.busy = r; n.drain = 1'b0; n.phase = 0; n.pix = 0;
    end else begin
      n.phase = (m.phase + 1) % d;
      if (pe) n.pix = (m.pix + 1) % T;
      if (!m.drain) n.drain = !r;
      else if (r) n.drain = 1'b0;
      else if (fend) begin
        n.busy = 1'b0; n.drain = 1'b0; n.phase = 0; n.pix = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [25:0] mdl_out(mdl_t m, int d);
    int h = m.pix % SHT;
    int v = m.pix / SHT;
    bit pe = m.busy && (m.phase == d - 1);
    bit disp = m.busy && (h < SHA) && (v < SVA);
    return {m.busy, pe, pe && (m.pix == 0), disp,
            !((h >= SHA + SHF) && (h < SHA + SHF + SHS)),
            !((v >= SVA + SVF) && (v < SVA + SVF + SVS)),
            disp ? 10'(h) : 10'd0, disp ? 10'(v) : 10'd0};
  endfunction

  task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  vec_t tbl[8];
  mdl_t ms, m1;

  initial begin
    int found, k, first_low, low_cnt, fall_k, line1_c, fs_cnt, vs_low, seg;
    bit r;

    tbl[0] = '{1'b0, IDLE_V};
    tbl[1] = '{1'b0, IDLE_V};
    tbl[2] = '{1'b1, START_V};
    tbl[3] = '{1'b1, FIRST_V};
    tbl[4] = '{1'b1, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 10'd0}};
    tbl[5] = '{1'b0, {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 10'd0}};
    tbl[6] = '{1'b0, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 10'd0}};
    tbl[7] = '{1'b1, {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 10'd0}};

    s_rst_n = 1'b0; s_run = 1'b0; d_rst_n = 1'b0; d_run = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_small", obs_s, IDLE_V);
    chk("reset_div1", obs_1, IDLE_V);
    chk("reset_def", obs_d, IDLE_V);

    // Vector table: idle hold, start, first strobe, drain and resume.
    s_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_run = tbl[i].run;
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs_s, tbl[i].exp);
    end

    // Asynchronous reset in the middle of a sync pulse, then restart.
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (!s_hs && !s_vs) found = 1;
    end
    chk_int("reach_sync", found, 1);
    #2 s_rst_n = 1'b0;
    #1 chk("async_rst", obs_s, IDLE_V);
    @(negedge clk);
    s_rst_n = 1'b1;
    @(negedge clk);
    chk("restart_busy", obs_s, START_V);
    @(negedge clk);
    chk("restart_fs", obs_s, FIRST_V);

    // Default geometry: first pixel timing and one full line.
    d_run = 1'b1;
    @(negedge clk);
    d_rst_n = 1'b1;
    k = 0; first_low = -1; low_cnt = 0; fall_k = -1; line1_c = -1; fs_cnt = 0; vs_low = 0;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      if (c == 1) chk("def_busy", obs_d, START_V);
      if (c == 2) chk("def_first", obs_d, FIRST_V);
      if (d_pix) begin
        if (!d_hs && first_low < 0) first_low = k;
        if (!d_hs && k < 800) low_cnt++;
        if (!d_disp && fall_k < 0) fall_k = k;
        if (d_disp && d_x == 10'd0 && d_y == 10'd1 && line1_c < 0) line1_c = c;
        if (d_fs) fs_cnt++;
        if (!d_vs) vs_low++;
        k++;
      end
    end
    chk_int("def_hsync_start", first_low, 656);
    chk_int("def_hsync_len", low_cnt, 96);
    chk_int("def_disp_fall", fall_k, 640);
    chk_int("def_line_period", line1_c - 2, 1600);
    chk_int("def_frame_start", fs_cnt, 1);
    chk_int("def_vsync_low", vs_low, 0);
    chk_int("def_strobes", k, 850);
    d_rst_n = 1'b0;

    // Random run pattern against the model for both small instances.
    s_rst_n = 1'b0; s_run = 1'b0;
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    ms = '{1'b0, 1'b0, 0, 0};
    m1 = '{1'b0, 1'b0, 0, 0};
    seg = 0; r = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      chk("rand_small", obs_s, mdl_out(ms, 2));
      chk("rand_div1", obs_1, mdl_out(m1, 1));
      if (seg == 0) begin
        r = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 900);
      end
      seg--;
      s_run = r;
      ms = mdl_next(ms, r, 2);
      m1 = mdl_next(m1, r, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 2, meaning system clocks per pixel (legal range 1..16).
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-003 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal front porch, sync and back porch widths in pixels.
REQ-004 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-005 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33, meaning vertical front porch, sync and back porch widths in lines.
REQ-006 SHALL have port clk_in, input, 1, system clock (50 MHz nominal); the block uses this one clock only.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port run, input, 1, level request to scan frames.
REQ-009 SHALL have port pix_en, output, 1, one-cycle pixel strobe.
REQ-010 SHALL have ports hsync and vsync, output, 1 each, active-low sync pulses.
REQ-011 SHALL have port disp_en, output, 1, high while the current pixel is visible.
REQ-012 SHALL have ports x and y, output, 10 each, visible pixel coordinates.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse at the first pixel of each frame.
REQ-014 SHALL have port busy, output, 1, high while scanning.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN and DRAIN.
REQ-016 IDLE->SCAN SHALL occur on the clock edge where run=1; SCAN->DRAIN on the edge where run=0; DRAIN->SCAN on the edge where run=1.
REQ-017 DRAIN->IDLE SHALL occur on the pix_en edge where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, i.e. only at a frame end, so a started frame is always completed.
REQ-018 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525); both totals SHALL be at most 1024.
REQ-019 Divider counter div_cnt SHALL be held at 0 in IDLE, increment each clk in SCAN/DRAIN, and wrap from DIV-1 to 0.
REQ-020 pix_en SHALL be high exactly in cycles where state is SCAN or DRAIN and div_cnt=DIV-1, so the first strobe comes DIV cycles after entering SCAN; with DIV=1 it is high every scanning cycle.
REQ-021 h_cnt SHALL advance on pix_en and wrap from H_TOTAL-1 to 0; v_cnt SHALL advance when h_cnt wraps and wrap from V_TOTAL-1 to 0.
REQ-022 Outputs SHALL decode the registered h_cnt/v_cnt of the same cycle: hsync=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); vsync=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-023 disp_en SHALL be 1 iff busy, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x and y SHALL equal h_cnt and v_cnt when disp_en=1, and 0 otherwise.
REQ-024 frame_start SHALL equal pix_en AND h_cnt=0 AND v_cnt=0; it fires on the first strobe after each IDLE->SCAN transition and once per frame afterwards.
REQ-025 busy SHALL be 1 in SCAN and DRAIN and 0 in IDLE.
REQ-026 In IDLE, h_cnt and v_cnt SHALL be 0, pix_en=0, hsync=vsync=1 and disp_en=0.
REQ-027 run toggling within a single frame SHALL NOT disturb the counters; only the state changes.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, div_cnt=h_cnt=v_cnt=0, pix_en=0, hsync=1, vsync=1, disp_en=0, x=0, y=0, frame_start=0, busy=0, including mid-frame.
REQ-029 After rst_n deasserts, the block SHALL stay in IDLE until the first clock edge that samples run=1.

Verification
REQ-030 run=1 held from reset release -> busy=1 after one clk; first pix_en 2 clks later with frame_start=1, disp_en=1, x=0, y=0.
REQ-031 Line check -> hsync low for exactly 96 strobes starting at x position 656; line period 800 strobes = 1600 clk; disp_en falls at the 639->640 transition.
REQ-032 Frame check -> vsync low on lines 490-491 only; frame period 420000 strobes = 840000 clk; exactly one frame_start per frame.
REQ-033 run dropped at (h=100, v=200) -> scanning continues to (799,524), then busy=0 and outputs at idle values; a second run with run reasserted at v=300 -> no stop, and the next frame_start arrives on time.
REQ-034 rst_n pulsed low at (h=700, v=491) -> hsync=1 and vsync=1 immediately; after release with run=1, scanning restarts at (0,0) with frame_start.
REQ-035 DIV=1 build -> pix_en continuous while busy; line period 800 clk.
